// File: rtl/stage_e_pkg.sv
// Shared types and constants for the MIPS execute stage.
package stage_e_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;
    localparam int unsigned MAX_LAT  = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W    = $clog2(MAX_LAT);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_SLLV = 4'hB,
        ALU_SRLV = 4'hC,
        ALU_SRAV = 4'hD,
        ALU_LUI  = 4'hE
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam logic [1:0] FWD_OWN = 2'b00;
    localparam logic [1:0] FWD_M   = 2'b01;
    localparam logic [1:0] FWD_W   = 2'b10;

    localparam logic [1:0] CSEL_ALU = 2'b00;
    localparam logic [1:0] CSEL_HI  = 2'b01;
    localparam logic [1:0] CSEL_LO  = 2'b10;

endpackage

// File: rtl/stage_e_if.sv
// Execute-stage bundle: D/E operands and controls in, E/M results and Busy out.
interface stage_e_if;
    import stage_e_pkg::*;

    logic [DATA_W-1:0] RS_E;
    logic [DATA_W-1:0] RT_E;
    logic [DATA_W-1:0] Ext_E;
    logic [4:0]        Shamt_E;
    logic [DATA_W-1:0] RFWD_M;
    logic [DATA_W-1:0] RFWD_W;
    logic [1:0]        FwdA_Sel;
    logic [1:0]        FwdB_Sel;
    logic              BSel;
    alu_op_e           ALUOp;
    md_op_e            MDOp;
    logic              Start;
    logic [1:0]        CSel;
    logic [DATA_W-1:0] C_E;
    logic [DATA_W-1:0] WD_E;
    logic              Busy;

    modport master (
        output RS_E, RT_E, Ext_E, Shamt_E, RFWD_M, RFWD_W,
        output FwdA_Sel, FwdB_Sel, BSel, ALUOp, MDOp, Start, CSel,
        input  C_E, WD_E, Busy
    );

    modport slave (
        input  RS_E, RT_E, Ext_E, Shamt_E, RFWD_M, RFWD_W,
        input  FwdA_Sel, FwdB_Sel, BSel, ALUOp, MDOp, Start, CSel,
        output C_E, WD_E, Busy
    );

endinterface

// File: rtl/stage_e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers; results commit on the edge that drops busy.
module stage_e_mdu
    import stage_e_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  md_op_e            md_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } mdu_state_e;

    mdu_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_signed;

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;

    // Results are computed from the latched operands and only consumed at count zero.
    always_comb begin
        prod = '0;
        quo  = '0;
        rem  = '0;
        if (op_signed) begin
            prod = 64'($signed({{DATA_W{op_a[DATA_W-1]}}, op_a}) *
                       $signed({{DATA_W{op_b[DATA_W-1]}}, op_b}));
        end else begin
            prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
        end
        if (op_b == '0) begin
            quo = '1;
            rem = op_a;
        end else if (op_signed) begin
            // Most-negative / -1 overflows; wrap the quotient like the hardware would.
            if (op_a == 32'h8000_0000 && op_b == '1) begin
                quo = op_a;
                rem = '0;
            end else begin
                quo = 32'($signed(op_a) / $signed(op_b));
                rem = 32'($signed(op_a) % $signed(op_b));
            end
        end else begin
            quo = op_a / op_b;
            rem = op_a % op_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU: begin
                                state     <= S_MUL;
                                cnt       <= CNT_W'(MULT_LAT - 1);
                                op_a      <= a;
                                op_b      <= b;
                                op_signed <= (md_op == MD_MULT);
                                busy      <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                state     <= S_DIV;
                                cnt       <= CNT_W'(DIV_LAT - 1);
                                op_a      <= a;
                                op_b      <= b;
                                op_signed <= (md_op == MD_DIV);
                                busy      <= 1'b1;
                            end
                            MD_MTHI: hi <= a;
                            MD_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        hi    <= prod[2*DATA_W-1:DATA_W];
                        lo    <= prod[DATA_W-1:0];
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (cnt == '0) begin
                        hi    <= rem;
                        lo    <= quo;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stage_e.sv
// MIPS execute stage: operand forwarding, ALU and HI/LO result muxing.
// The multiply/divide unit is present only when STAGE_E_MDU_EN is defined.
module stage_e
    import stage_e_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    stage_e_if.slave  bus
);

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;

    always_comb begin
        case (bus.FwdA_Sel)
            FWD_M:   fwd_a = bus.RFWD_M;
            FWD_W:   fwd_a = bus.RFWD_W;
            default: fwd_a = bus.RS_E;
        endcase
        case (bus.FwdB_Sel)
            FWD_M:   fwd_b = bus.RFWD_M;
            FWD_W:   fwd_b = bus.RFWD_W;
            default: fwd_b = bus.RT_E;
        endcase
        alu_b = bus.BSel ? bus.Ext_E : fwd_b;
    end

    always_comb begin
        case (bus.ALUOp)
            ALU_ADD:  alu_y = fwd_a + alu_b;
            ALU_SUB:  alu_y = fwd_a - alu_b;
            ALU_AND:  alu_y = fwd_a & alu_b;
            ALU_OR:   alu_y = fwd_a | alu_b;
            ALU_XOR:  alu_y = fwd_a ^ alu_b;
            ALU_NOR:  alu_y = ~(fwd_a | alu_b);
            ALU_SLT:  alu_y = DATA_W'($signed(fwd_a) < $signed(alu_b));
            ALU_SLTU: alu_y = DATA_W'(fwd_a < alu_b);
            ALU_SLL:  alu_y = alu_b << bus.Shamt_E;
            ALU_SRL:  alu_y = alu_b >> bus.Shamt_E;
            ALU_SRA:  alu_y = DATA_W'($signed(alu_b) >>> bus.Shamt_E);
            ALU_SLLV: alu_y = alu_b << fwd_a[4:0];
            ALU_SRLV: alu_y = alu_b >> fwd_a[4:0];
            ALU_SRAV: alu_y = DATA_W'($signed(alu_b) >>> fwd_a[4:0]);
            ALU_LUI:  alu_y = {alu_b[15:0], 16'h0000};
            default:  alu_y = '0;
        endcase
    end

`ifdef STAGE_E_MDU_EN
    stage_e_mdu u_mdu (
        .clk   (clk),
        .reset (reset),
        .start (bus.Start),
        .md_op (bus.MDOp),
        .a     (fwd_a),
        .b     (fwd_b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy)
    );
`else
    // Without the MDU, HI/LO read as zero and launches are dropped.
    logic unused_mdu;
    assign unused_mdu = ^{clk, reset, bus.Start, bus.MDOp};
    assign hi   = '0;
    assign lo   = '0;
    assign busy = 1'b0;
`endif

    always_comb begin
        case (bus.CSel)
            CSEL_HI: bus.C_E = hi;
            CSEL_LO: bus.C_E = lo;
            default: bus.C_E = alu_y;
        endcase
    end

    assign bus.WD_E = fwd_b;
    assign bus.Busy = busy;

endmodule
